// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - ID/EXE input bundle and EXE/MEM output bundle of the execute stage
//
// Purpose: groups the execute stage handshake and pipeline-register signals.
//   master : the side that presents ID/EXE and consumes EXE/MEM (ID stage / bench)
//   slave  : the execute stage itself
// Signals:
//   in_valid/in_ready                   ID/EXE handshake
//   ewreg em2reg ewmem ejal ealuc ealuimm eshift epc4 eimm ea eb ern   ID/EXE bundle
//   out_valid mwreg mm2reg mwmem malu mb mrn                           EXE/MEM bundle
//   busy                                multiply/divide unit iterating
interface exe_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic        ewreg;
    logic        em2reg;
    logic        ewmem;
    logic        ejal;
    logic [3:0]  ealuc;
    logic        ealuimm;
    logic        eshift;
    logic [31:0] epc4;
    logic [31:0] eimm;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [4:0]  ern;
    logic        out_valid;
    logic        mwreg;
    logic        mm2reg;
    logic        mwmem;
    logic [31:0] malu;
    logic [31:0] mb;
    logic [4:0]  mrn;
    logic        busy;

    modport master (
        output in_valid, ewreg, em2reg, ewmem, ejal, ealuc, ealuimm, eshift,
               epc4, eimm, ea, eb, ern,
        input  in_ready, out_valid, mwreg, mm2reg, mwmem, malu, mb, mrn, busy
    );

    modport slave (
        input  in_valid, ewreg, em2reg, ewmem, ejal, ealuc, ealuimm, eshift,
               epc4, eimm, ea, eb, ern,
        output in_ready, out_valid, mwreg, mm2reg, mwmem, malu, mb, mrn, busy
    );
endinterface

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - pipeline execute stage with iterative multiply/divide and HI/LO
//
// Purpose: ALU, JAL link and store-data generation registered into the EXE/MEM
//   bundle, plus a 32-cycle shift-add multiplier / restoring divider that stalls
//   the ID/EXE register (in_ready=0) while iterating.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  exe_stage_if.slave (ID/EXE in, EXE/MEM out, busy)
// Optional feature: define SIGNED_MULDIV_EN to enable ALU codes 1110 (MULT) and
//   1111 (DIV) as signed operations; otherwise those codes return 0.
module exe_stage #(
    parameter logic [31:0] LINK_OFFSET = 32'd4,
    parameter int          MD_CYCLES   = 32
) (
    input  logic        clk,
    input  logic        rst,
    exe_stage_if.slave  bus
);

    localparam logic [4:0] LP_LAST = 5'(MD_CYCLES - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    // Working registers: r_md_hi = partial product / partial remainder,
    // r_md_lo = multiplier being shifted out / quotient being shifted in,
    // r_md_d  = multiplicand / divisor.
    logic [31:0] r_md_hi;
    logic [31:0] r_md_lo;
    logic [31:0] r_md_d;
    logic        r_md_div;
`ifdef SIGNED_MULDIV_EN
    logic        r_neg_q;
    logic        r_neg_r;
`endif

    logic        r_out_valid;
    logic        r_mwreg;
    logic        r_mm2reg;
    logic        r_mwmem;
    logic [31:0] r_malu;
    logic [31:0] r_mb;
    logic [4:0]  r_mrn;

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_alu;
    logic [31:0] w_result;
    logic        w_accept;
    logic        w_is_md;
    logic        w_div_sel;
    logic [31:0] w_a_op;
    logic [31:0] w_b_op;

    logic [32:0] w_mul_sum;
    logic [32:0] w_div_sh;
    logic [32:0] w_div_tr;
    logic        w_div_ge;
    logic [31:0] w_nxt_hi;
    logic [31:0] w_nxt_lo;
    logic [31:0] w_fin_hi;
    logic [31:0] w_fin_lo;
    logic        w_unused_borrow;

    assign w_a      = bus.eshift  ? {27'b0, bus.eimm[10:6]} : bus.ea;
    assign w_b      = bus.ealuimm ? bus.eimm : bus.eb;
    assign w_accept = bus.in_valid & (r_state == S_IDLE);

    always_comb begin
        w_alu = 32'd0;
        case (bus.ealuc)
            4'b0000: w_alu = w_a + w_b;
            4'b0001: w_alu = w_a - w_b;
            4'b0010: w_alu = w_a & w_b;
            4'b0011: w_alu = w_a | w_b;
            4'b0100: w_alu = w_a ^ w_b;
            4'b0101: w_alu = w_b << 16;
            4'b0110: w_alu = w_b << w_a[4:0];
            4'b0111: w_alu = w_b >> w_a[4:0];
            4'b1000: w_alu = $signed(w_b) >>> w_a[4:0];
            4'b1001: w_alu = ($signed(w_a) < $signed(w_b)) ? 32'd1 : 32'd0;
            4'b1100: w_alu = r_hi;
            4'b1101: w_alu = r_lo;
            default: w_alu = 32'd0;
        endcase
    end

    assign w_result = bus.ejal ? (bus.epc4 + LINK_OFFSET) : w_alu;

`ifdef SIGNED_MULDIV_EN
    logic w_sgn;
    logic w_a_neg;
    logic w_b_neg;
    logic w_b_zero;
    logic w_neg_q;
    logic w_neg_r;
    logic [63:0] w_prod_raw;
    logic [63:0] w_prod_fix;

    assign w_is_md   = ~bus.ejal & (bus.ealuc[3:1] == 3'b101 || bus.ealuc[3:1] == 3'b111);
    assign w_div_sel = ~bus.ejal & (bus.ealuc == 4'b1011 || bus.ealuc == 4'b1111);
    assign w_sgn     = ~bus.ejal & (bus.ealuc[3:1] == 3'b111);
    assign w_a_neg   = w_sgn & w_a[31];
    assign w_b_neg   = w_sgn & w_b[31];
    assign w_b_zero  = (w_b == 32'd0);
    // Divide by zero keeps the raw dividend and skips sign fix-up so the
    // result matches the unsigned case: LO=all ones, HI=dividend.
    assign w_a_op    = (w_a_neg & ~(w_div_sel & w_b_zero)) ? (32'd0 - w_a) : w_a;
    assign w_b_op    = w_b_neg ? (32'd0 - w_b) : w_b;
    assign w_neg_q   = (w_a_neg ^ w_b_neg) & ~(w_div_sel & w_b_zero);
    assign w_neg_r   = w_a_neg & w_div_sel & ~w_b_zero;
`else
    assign w_is_md   = ~bus.ejal & (bus.ealuc[3:1] == 3'b101);
    assign w_div_sel = ~bus.ejal & (bus.ealuc == 4'b1011);
    assign w_a_op    = w_a;
    assign w_b_op    = w_b;
`endif

    // One shift-add multiply step: add multiplicand when the multiplier LSB is
    // set, then shift the 65-bit {carry, hi, lo} right by one.
    assign w_mul_sum = {1'b0, r_md_hi} + (r_md_lo[0] ? {1'b0, r_md_d} : 33'd0);
    // One restoring divide step: shift the next dividend bit into the remainder
    // and subtract the divisor when it fits.
    assign w_div_sh  = {r_md_hi, r_md_lo[31]};
    assign w_div_tr  = w_div_sh - {1'b0, r_md_d};
    assign w_div_ge  = (w_div_sh >= {1'b0, r_md_d});
    assign w_unused_borrow = w_div_tr[32];

    assign w_nxt_hi = r_md_div ? (w_div_ge ? w_div_tr[31:0] : w_div_sh[31:0])
                               : w_mul_sum[32:1];
    assign w_nxt_lo = r_md_div ? {r_md_lo[30:0], w_div_ge}
                               : {w_mul_sum[0], r_md_lo[31:1]};

`ifdef SIGNED_MULDIV_EN
    assign w_prod_raw = {w_nxt_hi, w_nxt_lo};
    assign w_prod_fix = r_neg_q ? (64'd0 - w_prod_raw) : w_prod_raw;
    assign w_fin_hi   = r_md_div ? (r_neg_r ? (32'd0 - w_nxt_hi) : w_nxt_hi) : w_prod_fix[63:32];
    assign w_fin_lo   = r_md_div ? (r_neg_q ? (32'd0 - w_nxt_lo) : w_nxt_lo) : w_prod_fix[31:0];
`else
    assign w_fin_hi   = w_nxt_hi;
    assign w_fin_lo   = w_nxt_lo;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_md_hi     <= 32'd0;
            r_md_lo     <= 32'd0;
            r_md_d      <= 32'd0;
            r_md_div    <= 1'b0;
`ifdef SIGNED_MULDIV_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
            r_out_valid <= 1'b0;
            r_mwreg     <= 1'b0;
            r_mm2reg    <= 1'b0;
            r_mwmem     <= 1'b0;
            r_malu      <= 32'd0;
            r_mb        <= 32'd0;
            r_mrn       <= 5'd0;
        end else begin
            // Multiply/divide issue travels down the pipe as a bubble.
            r_out_valid <= w_accept;
            r_mwreg     <= w_accept & bus.ewreg & ~w_is_md;
            r_mwmem     <= w_accept & bus.ewmem & ~w_is_md;
            if (w_accept) begin
                r_mm2reg <= bus.em2reg;
                r_malu   <= w_result;
                r_mb     <= bus.eb;
                r_mrn    <= bus.ern;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_md) begin
                        r_state  <= S_BUSY;
                        r_cnt    <= 5'd0;
                        r_md_hi  <= 32'd0;
                        r_md_lo  <= w_a_op;
                        r_md_d   <= w_b_op;
                        r_md_div <= w_div_sel;
`ifdef SIGNED_MULDIV_EN
                        r_neg_q  <= w_neg_q;
                        r_neg_r  <= w_neg_r;
`endif
                    end
                end
                S_BUSY: begin
                    r_md_hi <= w_nxt_hi;
                    r_md_lo <= w_nxt_lo;
                    r_cnt   <= r_cnt + 5'd1;
                    if (r_cnt == LP_LAST) begin
                        r_hi    <= w_fin_hi;
                        r_lo    <= w_fin_lo;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state == S_BUSY);
    assign bus.out_valid = r_out_valid;
    assign bus.mwreg     = r_mwreg;
    assign bus.mm2reg    = r_mm2reg;
    assign bus.mwmem     = r_mwmem;
    assign bus.malu      = r_malu;
    assign bus.mb        = r_mb;
    assign bus.mrn       = r_mrn;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - scoreboard testbench for exe_stage
module tb_exe_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_stage_if bus();
    exe_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

`ifdef SIGNED_MULDIV_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int          id;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
        logic        wreg;
        logic        wmem;
        logic        m2reg;
        logic        chk_alu;
    } exp_t;

    exp_t sb[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Monitor: every valid EXE/MEM bundle must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", {31'b0, bus.out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_alu) chk($sformatf("v%0d_malu", e.id), bus.malu, e.alu);
                chk($sformatf("v%0d_mwreg", e.id), {31'b0, bus.mwreg}, {31'b0, e.wreg});
                chk($sformatf("v%0d_mwmem", e.id), {31'b0, bus.mwmem}, {31'b0, e.wmem});
                chk($sformatf("v%0d_mrn", e.id), {27'b0, bus.mrn}, {27'b0, e.rn});
                chk($sformatf("v%0d_mb", e.id), bus.mb, e.b);
                chk($sformatf("v%0d_mm2reg", e.id), {31'b0, bus.mm2reg}, {31'b0, e.m2reg});
            end
        end
    end

    task automatic issue(input int id, input logic [3:0] aluc,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic shift, input logic aluimm, input logic jal,
                         input logic wreg, input logic wmem, input logic m2reg,
                         input logic [4:0] rn, input logic [31:0] pc4,
                         input logic [31:0] exp_alu, input logic chk_alu,
                         output int wait_cyc);
        exp_t e;
        logic is_md;
        @(negedge clk);
        bus.ealuc = aluc; bus.ea = a; bus.eb = b; bus.eimm = imm;
        bus.eshift = shift; bus.ealuimm = aluimm; bus.ejal = jal;
        bus.ewreg = wreg; bus.ewmem = wmem; bus.em2reg = m2reg;
        bus.ern = rn; bus.epc4 = pc4; bus.in_valid = 1'b1;
        wait_cyc = 0;
        while (bus.in_ready !== 1'b1 && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (bus.in_ready !== 1'b1) begin
            chk($sformatf("v%0d_accept_timeout", id), {31'b0, bus.in_ready}, 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            is_md = !jal && (aluc == 4'b1010 || aluc == 4'b1011 ||
                             (SIGNED_EN && (aluc == 4'b1110 || aluc == 4'b1111)));
            e.id = id; e.alu = exp_alu; e.b = b; e.rn = rn;
            e.wreg = wreg & ~is_md; e.wmem = wmem & ~is_md;
            e.m2reg = m2reg; e.chk_alu = chk_alu;
            sb.push_back(e);
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    int w;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 0; bus.ewreg = 0; bus.em2reg = 0; bus.ewmem = 0; bus.ejal = 0;
        bus.ealuc = 0; bus.ealuimm = 0; bus.eshift = 0; bus.epc4 = 0; bus.eimm = 0;
        bus.ea = 0; bus.eb = 0; bus.ern = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_malu", bus.malu, 32'd0);
        chk("rst_mrn", {27'b0, bus.mrn}, 32'd0);
        chk("rst_mwreg", {31'b0, bus.mwreg}, 32'd0);
        rst = 1'b0;

        // ADD wraps
        issue(1, 4'b0000, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0, 0, 1, 0, 0, 5'd5, 32'd0, 32'd0, 1, w);
        // SRA by shamt from eimm[10:6]=4
        issue(2, 4'b1000, 32'd0, 32'h80000000, 32'h00000100, 1, 0, 0, 1, 0, 0, 5'd6, 32'd0, 32'hF8000000, 1, w);
        // Bubble: out_valid/mwreg drop, malu/mrn hold
        @(negedge clk);
        @(negedge clk);
        chk("bubble_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("bubble_mwreg", {31'b0, bus.mwreg}, 32'd0);
        chk("bubble_malu_hold", bus.malu, 32'hF8000000);
        chk("bubble_mrn_hold", {27'b0, bus.mrn}, 32'd6);
        // SLT signed
        issue(3, 4'b1001, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0, 0, 1, 0, 0, 5'd7, 32'd0, 32'd1, 1, w);
        // JAL overrides ALU code
        issue(4, 4'b0011, 32'h12345678, 32'h0, 32'd0, 0, 0, 1, 1, 0, 0, 5'd31, 32'h00400010, 32'h00400014, 1, w);
        // Store: address = ea + imm, store data = eb
        issue(5, 4'b0000, 32'h00000100, 32'hDEADBEEF, 32'd8, 0, 1, 0, 0, 1, 0, 5'd0, 32'd0, 32'h00000108, 1, w);
        // LUI as a load-style bundle (m2reg)
        issue(6, 4'b0101, 32'd0, 32'd0, 32'h00001234, 0, 1, 0, 1, 0, 1, 5'd8, 32'd0, 32'h12340000, 1, w);
        // SUB wraps, SLL
        issue(7, 4'b0001, 32'd5, 32'd7, 32'd0, 0, 0, 0, 1, 0, 0, 5'd9, 32'd0, 32'hFFFFFFFE, 1, w);
        issue(8, 4'b0110, 32'd4, 32'h0000000F, 32'd0, 0, 0, 0, 1, 0, 0, 5'd10, 32'd0, 32'h000000F0, 1, w);

        // MULTU FFFFFFFF * 2, issued with wreg/wmem set to check bubble forcing
        issue(9, 4'b1010, 32'hFFFFFFFF, 32'd2, 32'd0, 0, 0, 0, 1, 1, 0, 5'd11, 32'd0, 32'd0, 0, w);
        chk("mul_busy", {31'b0, bus.busy}, 32'd1);
        chk("mul_in_ready", {31'b0, bus.in_ready}, 32'd0);
        // MFHI presented while busy: held then accepted
        issue(10, 4'b1100, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd12, 32'd0, 32'd1, 1, w);
        chk("mul_ready_low_cycles", w, 32'd32);
        issue(11, 4'b1101, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd13, 32'd0, 32'hFFFFFFFE, 1, w);

        // DIVU by zero
        issue(12, 4'b1011, 32'd7, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd14, 32'd0, 32'd0, 0, w);
        issue(13, 4'b1101, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd15, 32'd0, 32'hFFFFFFFF, 1, w);
        chk("div0_ready_low_cycles", w, 32'd32);
        issue(14, 4'b1100, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd16, 32'd0, 32'd7, 1, w);
        // DIVU 100/7
        issue(15, 4'b1011, 32'd100, 32'd7, 32'd0, 0, 0, 0, 1, 0, 0, 5'd17, 32'd0, 32'd0, 0, w);
        issue(16, 4'b1101, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd18, 32'd0, 32'd14, 1, w);
        issue(17, 4'b1100, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd19, 32'd0, 32'd2, 1, w);

`ifdef SIGNED_MULDIV_EN
        // DIV -7/2 -> q=-3, r=-1
        issue(18, 4'b1111, 32'hFFFFFFF9, 32'd2, 32'd0, 0, 0, 0, 1, 0, 0, 5'd20, 32'd0, 32'd0, 0, w);
        issue(19, 4'b1101, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd21, 32'd0, 32'hFFFFFFFD, 1, w);
        issue(20, 4'b1100, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd22, 32'd0, 32'hFFFFFFFF, 1, w);
        // MULT -3*5 = -15
        issue(21, 4'b1110, 32'hFFFFFFFD, 32'd5, 32'd0, 0, 0, 0, 1, 0, 0, 5'd23, 32'd0, 32'd0, 0, w);
        issue(22, 4'b1101, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd24, 32'd0, 32'hFFFFFFF1, 1, w);
        issue(23, 4'b1100, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd25, 32'd0, 32'hFFFFFFFF, 1, w);
        // 0x80000000 / -1
        issue(24, 4'b1111, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, 0, 0, 1, 0, 0, 5'd26, 32'd0, 32'd0, 0, w);
        issue(25, 4'b1101, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd27, 32'd0, 32'h80000000, 1, w);
        issue(26, 4'b1100, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd28, 32'd0, 32'd0, 1, w);
        // Signed divide by zero with negative dividend
        issue(27, 4'b1111, 32'hFFFFFFF9, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd29, 32'd0, 32'd0, 0, w);
        issue(28, 4'b1101, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd30, 32'd0, 32'hFFFFFFFF, 1, w);
        issue(29, 4'b1100, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd1, 32'd0, 32'hFFFFFFF9, 1, w);
`else
        // Codes 1110/1111 are plain single-cycle ops returning 0
        issue(18, 4'b1110, 32'd5, 32'd3, 32'd0, 0, 0, 0, 1, 0, 0, 5'd20, 32'd0, 32'd0, 1, w);
        chk("undef_in_ready", {31'b0, bus.in_ready}, 32'd1);
        issue(19, 4'b1111, 32'd9, 32'd3, 32'd0, 0, 0, 0, 1, 0, 0, 5'd21, 32'd0, 32'd0, 1, w);
        chk("undef_busy", {31'b0, bus.busy}, 32'd0);
        issue(20, 4'b1100, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd22, 32'd0, 32'd2, 1, w);
`endif

        // Asynchronous reset in the middle of a MULTU
        issue(40, 4'b1010, 32'd3, 32'd5, 32'd0, 0, 0, 0, 1, 0, 0, 5'd2, 32'd0, 32'd0, 0, w);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("arst_hi", dut.r_hi, 32'd0);
        chk("arst_lo", dut.r_lo, 32'd0);
        chk("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(41, 4'b1100, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd3, 32'd0, 32'd0, 1, w);
        issue(42, 4'b1101, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 5'd4, 32'd0, 32'd0, 1, w);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage; consumes the ID/EXE pipeline register outputs and produces the registered EXE/MEM bundle for the memory stage.
- Computes ALU results, JAL link values and store data.
- Owns an iterative 32-cycle unsigned multiply/divide unit with HI/LO registers.
- Deasserts in_ready while the multiply/divide unit is busy, so ID/EXE holds its contents.

Parameters:
LINK_OFFSET, 4, added to epc4 to form the JAL link value (epc4 + LINK_OFFSET = PC+8)
MD_CYCLES, 32, iteration count of the multiply/divide unit; only 32 is supported

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  ID/EXE bundle holds a real instruction
in_ready  out  1  stage accepts the bundle this cycle; 0 while BUSY
ewreg  in  1  instruction writes a GPR
em2reg  in  1  writeback data comes from memory
ewmem  in  1  store
ejal  in  1  JAL; result is the link value
ealuc  in  4  ALU operation code
ealuimm  in  1  operand B = eimm, else eb
eshift  in  1  operand A = {27'b0, eimm[10:6]}, else ea
epc4  in  32  PC+4 of the instruction
eimm  in  32  extended immediate
ea  in  32  register operand A
eb  in  32  register operand B
ern  in  5  destination register
out_valid  out  1  EXE/MEM bundle valid
mwreg  out  1  registered ewreg, forced 0 on bubbles
mm2reg  out  1  registered em2reg
mwmem  out  1  registered ewmem, forced 0 on bubbles
malu  out  32  ALU or link result
mb  out  32  store data (eb)
mrn  out  5  destination register
busy  out  1  multiply/divide unit iterating

Behaviour:
- Reset (async, active-high): state=IDLE; counter=0; HI=LO=0; out_valid, mwreg, mm2reg, mwmem=0; malu, mb=0; mrn=0. Reset mid-iteration discards the operation.
- Accept = in_valid & in_ready. in_ready = (state==IDLE).
- ALU codes (A/B after operand muxing):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 LUI = B<<16.
  - 0110 SLL = B<<A[4:0], 0111 SRL, 1000 SRA.
  - 1001 SLT = signed A<B ? 1 : 0.
  - 1010 MULTU, 1011 DIVU.
  - 1100 MFHI = HI, 1101 MFLO = LO.
  - 1110, 1111 = 0 unless the optional feature is enabled.
- All arithmetic wraps modulo 2^32; no overflow trap.
- ejal=1 overrides ealuc: malu = epc4 + LINK_OFFSET.
- Single-cycle op accepted at edge N: bundle registered at edge N; out_valid=1 for one cycle. Latency 1.
- Edge with no accept: out_valid=0, mwreg=0, mwmem=0 (bubble). malu/mb/mrn hold their previous values.
- MULTU/DIVU accepted: forwarded as a bubble (mwreg and mwmem forced 0, out_valid=1). State goes IDLE→BUSY with counter=0 and operands latched.
- BUSY: one shift-add (MULTU) or restoring-subtract (DIVU) step per cycle. At counter==MD_CYCLES-1, HI/LO are written and state→IDLE, so in_ready=1 the next cycle. in_ready is low for exactly 32 cycles after acceptance.
- MULTU result: {HI,LO} = A*B (64-bit unsigned).
- DIVU result: LO = quotient, HI = remainder.
- DIVU by zero: LO=32'hFFFFFFFF, HI=A. Still takes 32 cycles.
- MFHI/MFLO read HI/LO as committed. They cannot issue during BUSY because in_ready=0.
- busy = (state==BUSY).

Optional Feature:
- Macro SIGNED_MULDIV_EN.
- Defined: 1110 = MULT (signed 64-bit product) and 1111 = DIV (signed; quotient truncates toward zero, remainder takes the dividend's sign). Implemented by magnitude iteration plus sign fix-up in the final cycle; timing is identical to the unsigned ops.
- 32'h80000000 / -1: LO=32'h80000000, HI=0.
- Signed divide by zero behaves as DIVU by zero.
- Undefined: 1110/1111 yield malu=0, act as single-cycle ops, and never touch HI/LO.

Test Plan:
- Reset asserted mid-MULTU at cycle 10 of BUSY → busy=0, in_ready=1, HI=LO=0 immediately, without waiting for a clock edge.
- ADD ea=32'hFFFFFFFF, eb=1, ewreg=1, ern=5 → next edge malu=0, mwreg=1, mrn=5, out_valid=1.
- SRA with eshift=1, eimm[10:6]=4, eb=32'h80000000 → malu=32'hF8000000. SLT ea=-1, eb=1 → malu=1.
- JAL epc4=32'h00400010 → malu=32'h00400014.
- MULTU 32'hFFFFFFFF × 2 → in_ready low exactly 32 cycles; then MFHI→1 and MFLO→32'hFFFFFFFE. A bundle presented while busy is held and accepted on the first ready cycle.
- DIVU 7/0 → LO=32'hFFFFFFFF, HI=7. DIVU 100/7 → LO=14, HI=2. With SIGNED_MULDIV_EN, DIV -7/2 → LO=-3, HI=-1.
